// File: rtl/aesl_axis_stall_monitor_pkg.sv
//------------------------------------------------------------------------------
// aesl_monitor_pkg
// Shared FSM state type and index-width helper for the AXIS stall monitor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aesl_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } mon_state_t;

    // Index width for a channel vector; a single channel still needs one bit.
    function automatic int chan_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index width for the default four-channel configuration.
    localparam int CHAN_IDX_W = chan_idx_w(4);

endpackage

`default_nettype wire

// File: rtl/aesl_axis_stall_monitor_lowest_set_enc.sv
//------------------------------------------------------------------------------
// aesl_lowest_set_enc
// Combinational lowest-set-bit encoder with a valid flag (any bit set).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aesl_lowest_set_enc #(
    parameter int W     = 4,
    parameter int IDX_W = 2
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aesl_axis_stall_monitor.sv
//------------------------------------------------------------------------------
// aesl_axis_stall_monitor
// Flags a dataflow instance whose watched AXIS channels stay blocked for
// STALL_THRESHOLD consecutive cycles; keeps a sticky flag, the first blocked
// channel index and a saturating event count.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aesl_axis_stall_monitor
    import aesl_monitor_pkg::*;
#(
    parameter int NUM_AXIS        = 4,
    parameter int NUM_INST        = 6,
    parameter int STALL_THRESHOLD = 16,
    parameter int CNT_W           = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_AXIS-1:0]               axis_block_sigs,
    input  logic [NUM_AXIS-1:0]               chan_mask,
    input  logic [NUM_INST-1:0]               inst_idle_sigs,
    input  logic                              clear,
    output logic                              block,
    output logic                              block_sticky,
    output logic [chan_idx_w(NUM_AXIS)-1:0]   block_chan_idx,
    output logic [CNT_W-1:0]                  stall_count,
    output logic [CNT_W-1:0]                  event_count
);

    localparam int              IDX_W   = chan_idx_w(NUM_AXIS);
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(STALL_THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_AXIS-1:0] masked_blocks;
    logic [IDX_W-1:0]    low_idx;
    logic                any_blocked;
    logic                cond;
    logic                entry;
    logic [CNT_W-1:0]    stall_inc;
    logic [CNT_W-1:0]    stall_next;
    logic [CNT_W-1:0]    event_base;
    mon_state_t          state;
    mon_state_t          state_next;

    assign masked_blocks = axis_block_sigs & chan_mask;

    aesl_lowest_set_enc #(
        .W     (NUM_AXIS),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec   (masked_blocks),
        .idx   (low_idx),
        .valid (any_blocked)
    );

    // A fully idle instance cannot be deadlocked, whatever its ports say.
    assign cond      = any_blocked & ~(&inst_idle_sigs);
    assign stall_inc = stall_count + CNT_ONE;

    // Next-state and next run length for the stall FSM.
    always_comb begin
        state_next = state;
        stall_next = stall_count;
        case (state)
            IDLE: begin
                if (cond) begin
                    stall_next = CNT_ONE;
                    state_next = (THRESH == CNT_ONE) ? BLOCKED : COUNT;
                end
            end
            COUNT: begin
                if (cond) begin
                    stall_next = stall_inc;
                    if (stall_inc == THRESH) begin
                        state_next = BLOCKED;
                    end
                end else begin
                    stall_next = '0;
                    state_next = IDLE;
                end
            end
            BLOCKED: begin
                if (cond) begin
                    stall_next = (stall_count == CNT_MAX) ? stall_count : stall_inc;
                end else begin
                    stall_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                stall_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign entry      = (state_next == BLOCKED) && (state != BLOCKED);
    assign event_base = clear ? '0 : event_count;

    // FSM state and consecutive-stall run length.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            stall_count <= '0;
        end else begin
            state       <= state_next;
            stall_count <= stall_next;
        end
    end

    // Entry bookkeeping; an entry in the same cycle as clear takes precedence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            block_sticky   <= 1'b0;
            block_chan_idx <= '0;
            event_count    <= '0;
        end else if (entry) begin
            block_sticky   <= 1'b1;
            block_chan_idx <= low_idx;
            event_count    <= (event_base == CNT_MAX) ? event_base : event_base + CNT_ONE;
        end else if (clear) begin
            block_sticky   <= 1'b0;
            block_chan_idx <= '0;
            event_count    <= '0;
        end
    end

    // The state register already gives a registered flag.
    assign block = (state == BLOCKED);

endmodule

`default_nettype wire

// File: tb/tb_aesl_axis_stall_monitor.sv
`default_nettype none

module tb_aesl_axis_stall_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] axis_block_sigs = 4'h0;
    logic [3:0] chan_mask = 4'hF;
    logic [5:0] inst_idle_sigs = 6'h00;
    logic       clear = 1'b0;

    logic       b4, s4, b1, s1, b16, s16;
    logic [1:0] i4, i1, i16;
    logic [7:0] sc4, ec4, sc1, ec1, sc16, ec16;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    aesl_axis_stall_monitor #(.NUM_AXIS(4), .NUM_INST(6), .STALL_THRESHOLD(4), .CNT_W(8)) u_t4 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs), .chan_mask(chan_mask),
        .inst_idle_sigs(inst_idle_sigs), .clear(clear), .block(b4), .block_sticky(s4),
        .block_chan_idx(i4), .stall_count(sc4), .event_count(ec4));

    aesl_axis_stall_monitor #(.NUM_AXIS(4), .NUM_INST(6), .STALL_THRESHOLD(1), .CNT_W(8)) u_t1 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs), .chan_mask(chan_mask),
        .inst_idle_sigs(inst_idle_sigs), .clear(clear), .block(b1), .block_sticky(s1),
        .block_chan_idx(i1), .stall_count(sc1), .event_count(ec1));

    aesl_axis_stall_monitor #(.NUM_AXIS(4), .NUM_INST(6), .STALL_THRESHOLD(16), .CNT_W(8)) u_t16 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs), .chan_mask(chan_mask),
        .inst_idle_sigs(inst_idle_sigs), .clear(clear), .block(b16), .block_sticky(s16),
        .block_chan_idx(i16), .stall_count(sc16), .event_count(ec16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one clock and settle 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_block", 32'(b4), 0);
        chk("rst_sticky", 32'(s4), 0);
        chk("rst_idx", 32'(i4), 0);
        chk("rst_stall", 32'(sc4), 0);
        chk("rst_event", 32'(ec4), 0);
        reset = 1'b0;
        tick();

        // 1: ch2 blocked for 3 cycles, threshold 4 never reached
        axis_block_sigs = 4'b0100;
        tick(); chk("t1_stall1", 32'(sc4), 1); chk("t1_block1", 32'(b4), 0);
        tick(); chk("t1_stall2", 32'(sc4), 2); chk("t1_block2", 32'(b4), 0);
        tick(); chk("t1_stall3", 32'(sc4), 3); chk("t1_block3", 32'(b4), 0);
        axis_block_sigs = 4'b0000;
        tick(); chk("t1_stall0", 32'(sc4), 0); chk("t1_block4", 32'(b4), 0);
        chk("t1_event", 32'(ec4), 0);

        // 2: ch1|ch3 blocked for 6 cycles
        do_reset();
        axis_block_sigs = 4'b1010;
        tick(); tick(); tick();
        chk("t2_block_e3", 32'(b4), 0);
        chk("t2_stall_e3", 32'(sc4), 3);
        tick();
        chk("t2_block_e4", 32'(b4), 1);
        chk("t2_idx", 32'(i4), 1);
        chk("t2_event", 32'(ec4), 1);
        chk("t2_sticky", 32'(s4), 1);
        tick(); tick();
        chk("t2_block_e6", 32'(b4), 1);
        chk("t2_stall_e6", 32'(sc4), 6);
        axis_block_sigs = 4'b0000;
        tick();
        chk("t2_block_drop", 32'(b4), 0);
        chk("t2_stall_drop", 32'(sc4), 0);
        chk("t2_sticky_hold", 32'(s4), 1);
        chk("t2_event_hold", 32'(ec4), 1);

        // 5: clear coincident with entry (event_count was 1), then lone clear
        axis_block_sigs = 4'b1100;
        tick(); tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_block", 32'(b4), 1);
        chk("t5_sticky", 32'(s4), 1);
        chk("t5_event", 32'(ec4), 1);
        chk("t5_idx", 32'(i4), 2);
        axis_block_sigs = 4'b0000;
        tick();
        chk("t5_block_drop", 32'(b4), 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_lone_sticky", 32'(s4), 0);
        chk("t5_lone_event", 32'(ec4), 0);
        chk("t5_lone_idx", 32'(i4), 0);

        // 3: threshold 1, one-cycle pulse on ch0
        do_reset();
        axis_block_sigs = 4'b0001;
        chk("t3_block_pre", 32'(b1), 0);
        tick();
        axis_block_sigs = 4'b0000;
        chk("t3_block_on", 32'(b1), 1);
        chk("t3_event", 32'(ec1), 1);
        tick();
        chk("t3_block_off", 32'(b1), 0);

        // 4: ch2 blocked but suppressed by all-idle, then by mask
        do_reset();
        axis_block_sigs = 4'b0100;
        inst_idle_sigs  = 6'h3F;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_idle_block", 32'(b4), 0);
        end
        chk("t4_idle_stall", 32'(sc4), 0);
        inst_idle_sigs = 6'h00;
        chk("t4_idle_t1_block", 32'(b1), 0);
        chk("t4_idle_event", 32'(ec1), 0);
        chan_mask = 4'b1011;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_mask_block", 32'(b4), 0);
        end
        chk("t4_mask_t1_block", 32'(b1), 0);
        chk("t4_mask_event", 32'(ec4), 0);
        chan_mask = 4'hF;
        axis_block_sigs = 4'b0000;

        // 6: async reset mid-COUNT, then mid-BLOCKED
        do_reset();
        axis_block_sigs = 4'b0001;
        for (int i = 0; i < 7; i++) tick();
        chk("t6_stall7", 32'(sc16), 7);
        chk("t6_block_pre", 32'(b4), 1);
        reset = 1'b1;
        #1;
        chk("t6_cnt_stall", 32'(sc16), 0);
        chk("t6_cnt_b4", 32'(b4), 0);
        chk("t6_cnt_s4", 32'(s4), 0);
        chk("t6_cnt_e4", 32'(ec4), 0);
        #1;
        reset = 1'b0;
        tick();
        chk("t6_restart16", 32'(sc16), 1);
        chk("t6_restart4", 32'(sc4), 1);
        tick(); tick(); tick();
        chk("t6_blk_b4", 32'(b4), 1);
        chk("t6_blk_e4", 32'(ec4), 1);
        reset = 1'b1;
        #1;
        chk("t6_async_block", 32'(b4), 0);
        chk("t6_async_sticky", 32'(s4), 0);
        chk("t6_async_idx", 32'(i4), 0);
        chk("t6_async_stall", 32'(sc4), 0);
        chk("t6_async_event", 32'(ec4), 0);
        #1;
        reset = 1'b0;
        tick();
        chk("t6_restart_b", 32'(sc4), 1);
        chk("t6_restart_blk", 32'(b4), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
